taiga_trace_counters: RTL
=========================

# taiga_trace_counters

Performance-counter sink for the core's registered trace bundle (`tr`). Counts every single-bit trace event and accumulates the multi-bit occupancy events over a start/stop measurement window. Freezes all counts into a shadow bank on request. Exposes the shadow bank through a simple 1-cycle-latency read port for a debug/CSR bridge or testbench.

## Interface
- `COUNTER_W`, 48: counter width, legal range 33..64.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tr`  in  trace_outputs_t  registered trace bundle from the core; only `tr.events` is used.
- `start`  in  1  pulse; begin a measurement window.
- `stop`  in  1  pulse; end the window.
- `clear`  in  1  pulse; zero all live counters.
- `snapshot`  in  1  pulse; copy live counters into the shadow bank.
- `window_cycles`  in  32  window length, sampled on an accepted `start`; 0 = unlimited.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a window auto-expires.
- `rd_en`  in  1  read request.
- `rd_addr`  in  6  [5:1] counter index, [0] half select (0 = bits 31:0, 1 = bits COUNTER_W-1:32, zero-extended).
- `rd_valid`  out  1  read data valid.
- `rd_data`  out  32  read data.

## Operation
- Counter map:
  - Index 0: cycles spent in RUN.
  - Indices 1–24: the single-bit events, in this order: operand_stall, unit_stall, no_id_stall, no_instruction_stall, other_stall, instruction_issued_dec, branch_operand_stall, alu_operand_stall, ls_operand_stall, div_operand_stall, alu_op, branch_or_jump_op, load_op, store_op, mul_op, div_op, misc_op, branch_correct, branch_misspredict, return_correct, return_misspredict, rs1_forwarding_needed, rs2_forwarding_needed, rs1_and_rs2_forwarding_needed.
  - Indices 25–27: running sums of num_instructions_completing, num_instructions_in_flight and num_of_instructions_pending_writeback. Each value is zero-extended to COUNTER_W before it is added.
- State machine with two states, IDLE and RUN:
  - IDLE→RUN on `start`. On this transition, load `window_cycles` into a 32-bit down-counter.
  - RUN→IDLE on `stop`.
  - RUN→IDLE when the down-counter is nonzero-armed and reaches 1. `done` pulses on this transition.
  - `start` while in RUN is ignored, and the down-counter is not reloaded.
  - If `start` and `stop` arrive in the same cycle, `stop` wins. From IDLE the state stays IDLE; from RUN the state goes to IDLE.
- Counters increment only in cycles where the state is RUN, including the expiring cycle. The cycle in which `start` is accepted does not count. The cycle in which `stop` is accepted does count.
- All counters saturate at 2^COUNTER_W−1 and never wrap. An accumulation that would overflow clamps to all-ones.
- `clear` zeros all live counters and does not change the state. If `clear` and an increment occur in the same cycle, `clear` wins and the result is 0.
- `snapshot` copies all 28 live counter values as they were before this cycle's update. The shadow bank is otherwise stable.
- Reads always come from the shadow bank:
  - Index > 27 returns 0.
  - For the half-select bit, COUNTER_W bits above 32 are returned zero-padded.

## Timing
- Reset values:
  - State IDLE, `running` 0, `done` 0, `rd_valid` 0, `rd_data` 0.
  - All live counters, all shadow registers and the down-counter are 0.
- `running` is registered: high the cycle after `start` is accepted, low the cycle after the stop or expiry transition.
- With `window_cycles` = N > 0, exactly N RUN cycles occur. `done` is asserted in the cycle after the last counted cycle, coincident with `running` falling.
- An event on `tr` in cycle t is reflected in a live counter at t+1. It is visible through the read port after a `snapshot` at t+1 or later, with read latency 1.
- Read: `rd_en` at cycle t gives `rd_valid` = 1 and `rd_data` at t+1. One read per cycle, fully pipelined, with no backpressure. `rd_data` holds its last value when `rd_valid` = 0.
- If `snapshot` and `rd_en` occur in the same cycle, the read returns the old shadow value.
- Asserting `rst` mid-window returns everything to reset values immediately. No `done` pulse is produced.

## Test plan
- Window expiry:
  - Stimulus: `window_cycles` = 10, `start`, `tr.events.alu_op` held at 1, then `snapshot`.
  - Required: index 0 = 10, index 11 = 10, and `done` pulses once, 11 cycles after `start`.
- Manual window with multi-bit accumulation:
  - Stimulus: `window_cycles` = 0, `start`, drive num_instructions_in_flight = 3 for 4 cycles, `stop`, `snapshot`.
  - Required: index 26 = 12 and index 0 = 4. The `stop` cycle counts, so hold the value through it.
- Saturation:
  - Stimulus: force live counter 1 to 2^COUNTER_W−2, assert operand_stall for 3 RUN cycles, `snapshot`, read addr {1,0} and {1,1}.
  - Required: low half = 0xFFFFFFFF and high half = 2^(COUNTER_W−32)−1.
- Simultaneous events:
  - Stimulus: same-cycle `clear` + event.
  - Required: counter = 0.
  - Stimulus: same-cycle `start` + `stop` in IDLE.
  - Required: `running` stays 0.
  - Stimulus: `snapshot` + `rd_en`.
  - Required: the read returns the prior shadow value.
- Read port:
  - Stimulus: back-to-back `rd_en` to addresses 0, 1, 63.
  - Required: three consecutive `rd_valid` cycles, and addr 63 returns 0.
- Reset mid-run:
  - Stimulus: assert `rst` at cycle 5 of a 20-cycle window.
  - Required: `running` = 0, no `done` pulse, and all shadow reads = 0 after a `snapshot`.

Source files
------------

// File: rtl/taiga_trace_counters.sv
// Performance-counter sink for the core trace bundle: windowed live counters,
// a snapshot shadow bank and a 1-cycle-latency 32-bit read port.
package taiga_trace_pkg;
   typedef struct packed {
      logic       operand_stall;
      logic       unit_stall;
      logic       no_id_stall;
      logic       no_instruction_stall;
      logic       other_stall;
      logic       instruction_issued_dec;
      logic       branch_operand_stall;
      logic       alu_operand_stall;
      logic       ls_operand_stall;
      logic       div_operand_stall;
      logic       alu_op;
      logic       branch_or_jump_op;
      logic       load_op;
      logic       store_op;
      logic       mul_op;
      logic       div_op;
      logic       misc_op;
      logic       branch_correct;
      logic       branch_misspredict;
      logic       return_correct;
      logic       return_misspredict;
      logic       rs1_forwarding_needed;
      logic       rs2_forwarding_needed;
      logic       rs1_and_rs2_forwarding_needed;
      logic [2:0] num_instructions_completing;
      logic [4:0] num_instructions_in_flight;
      logic [4:0] num_of_instructions_pending_writeback;
   } taiga_trace_events_t;

   typedef struct packed {
      taiga_trace_events_t events;
   } trace_outputs_t;
endpackage

// One saturating live counter plus its shadow copy.
module taiga_trace_ctr #(
   parameter int COUNTER_W = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc_en,
   input  logic                 clear,
   input  logic                 snapshot,
   input  logic [COUNTER_W-1:0] addend,
   output logic [COUNTER_W-1:0] shadow
);
   logic [COUNTER_W-1:0] cnt;
   logic [COUNTER_W:0]   sum;

   assign sum = {1'b0, cnt} + {1'b0, addend};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         shadow <= '0;
      end else begin
         // shadow takes the pre-update value, so snapshot never sees this cycle's increment
         if (snapshot) shadow <= cnt;
         if (clear)
            cnt <= '0;
         else if (inc_en)
            cnt <= sum[COUNTER_W] ? '1 : sum[COUNTER_W-1:0];
      end
   end
endmodule

module taiga_trace_counters
   import taiga_trace_pkg::*;
#(
   parameter int COUNTER_W = 48
) (
   input  logic           clk,
   input  logic           rst,
   input  trace_outputs_t tr,
   input  logic           start,
   input  logic           stop,
   input  logic           clear,
   input  logic           snapshot,
   input  logic [31:0]    window_cycles,
   output logic           running,
   output logic           done,
   input  logic           rd_en,
   input  logic [5:0]     rd_addr,
   output logic           rd_valid,
   output logic [31:0]    rd_data
);
   localparam int NUM_CTRS = 28;
   localparam int NUM_EVTS = 24;

   typedef enum logic {IDLE, RUN} state_t;
   state_t      state;
   logic [31:0] dcnt;

   logic [NUM_EVTS-1:0]                ev_bits;
   logic [NUM_CTRS-1:0][COUNTER_W-1:0] addend;
   logic [NUM_CTRS-1:0][COUNTER_W-1:0] shadow;
   logic                               inc_en;

   assign inc_en = (state == RUN);

   // Bit i maps to counter index i+1
   assign ev_bits = {
      tr.events.rs1_and_rs2_forwarding_needed,
      tr.events.rs2_forwarding_needed,
      tr.events.rs1_forwarding_needed,
      tr.events.return_misspredict,
      tr.events.return_correct,
      tr.events.branch_misspredict,
      tr.events.branch_correct,
      tr.events.misc_op,
      tr.events.div_op,
      tr.events.mul_op,
      tr.events.store_op,
      tr.events.load_op,
      tr.events.branch_or_jump_op,
      tr.events.alu_op,
      tr.events.div_operand_stall,
      tr.events.ls_operand_stall,
      tr.events.alu_operand_stall,
      tr.events.branch_operand_stall,
      tr.events.instruction_issued_dec,
      tr.events.other_stall,
      tr.events.no_instruction_stall,
      tr.events.no_id_stall,
      tr.events.unit_stall,
      tr.events.operand_stall
   };

   always_comb begin
      addend    = '0;
      addend[0] = COUNTER_W'(1);
      for (int i = 0; i < NUM_EVTS; i++)
         addend[i+1] = {{(COUNTER_W-1){1'b0}}, ev_bits[i]};
      addend[25] = COUNTER_W'(tr.events.num_instructions_completing);
      addend[26] = COUNTER_W'(tr.events.num_instructions_in_flight);
      addend[27] = COUNTER_W'(tr.events.num_of_instructions_pending_writeback);
   end

   generate
      for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
         taiga_trace_ctr #(.COUNTER_W(COUNTER_W)) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .inc_en   (inc_en),
            .clear    (clear),
            .snapshot (snapshot),
            .addend   (addend[g]),
            .shadow   (shadow[g])
         );
      end
   endgenerate

   // Window control; a zero window_cycles leaves dcnt disarmed (manual stop only)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         running <= 1'b0;
         done    <= 1'b0;
         dcnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state   <= RUN;
                  running <= 1'b1;
                  dcnt    <= window_cycles;
               end
            end
            RUN: begin
               if (stop) begin
                  state   <= IDLE;
                  running <= 1'b0;
               end else if (dcnt == 32'd1) begin
                  state   <= IDLE;
                  running <= 1'b0;
                  done    <= 1'b1;
                  dcnt    <= '0;
               end else if (dcnt != '0) begin
                  dcnt <= dcnt - 32'd1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   logic [4:0]  rd_idx;
   logic [63:0] rd_ext;
   logic [31:0] rd_word;

   assign rd_idx = rd_addr[5:1];

   always_comb begin
      rd_ext = '0;
      if (rd_idx < 5'(NUM_CTRS))
         rd_ext = 64'(shadow[rd_idx]);
      rd_word = rd_addr[0] ? rd_ext[63:32] : rd_ext[31:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= rd_word;
      end
   end
endmodule
